// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU-to-word-RAM bridge: funct3 codes, FSM states,
// and the helpers that canonicalise access size and detect misalignment.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_RESP
  } state_t;

  // Unknown encodings fall back to a full-word access.
  function automatic logic [2:0] normalize_op(input logic [2:0] op, input logic store);
    logic [2:0] res;
    res = F3_W;
    if (store) begin
      if (op == F3_B || op == F3_H) res = op;
    end else begin
      if (op == F3_B || op == F3_H || op == F3_BU || op == F3_HU) res = op;
    end
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (op)
      F3_H, F3_HU: res = addr_lo[0];
      F3_W:        res = (addr_lo != 2'b00);
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load from a RAM word and merges
// store data into the captured word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses only look at addr_lo[1], which forces halfword alignment.
  always_comb begin
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (op)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic              sel;
      logic [LANE_W-1:0] src;
      always_comb begin
        sel = 1'b1;
        src = wdata[gi*LANE_W +: LANE_W];
        if (op == F3_B) begin
          sel = (addr_lo == 2'(gi));
          src = wdata[LANE_W-1:0];
        end else if (op == F3_H) begin
          sel = (addr_lo[1] == 1'(gi / 2));
          src = wdata[(gi % 2)*LANE_W +: LANE_W];
        end
      end
      assign store_word[gi*LANE_W +: LANE_W] = sel ? src : word[gi*LANE_W +: LANE_W];
    end
  endgenerate

endmodule

// File: rtl/lsu_ram_bridge.sv
// MEM-stage bridge turning RV32 byte/half/word loads and stores into word RAM
// cycles (RMW for sub-word stores). Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ram_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_store,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  input  logic [31:0]       ram_rdata
);

  localparam logic RD_LAT_ONE = (RD_LAT == 1);

  state_t            state_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic [31:0]       resp_rdata_reg;
  logic              resp_err_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [31:0]       ram_wdata_reg;
  logic              ram_wen_reg;
  logic [2:0]        op_reg;
  logic              store_reg;
  logic [1:0]        addr_lo_reg;
  logic [31:0]       wdata_reg;

  logic [2:0]  op_norm;
  logic        misalign;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign op_norm = normalize_op(req_op, req_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(op_norm, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .op         (op_reg),
    .addr_lo    (addr_lo_reg),
    .word       (ram_rdata),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= 32'd0;
      ram_wen_reg    <= 1'b0;
      op_reg         <= F3_W;
      store_reg      <= 1'b0;
      addr_lo_reg    <= 2'b00;
      wdata_reg      <= 32'd0;
    end else begin
      ram_wen_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            op_reg        <= op_norm;
            store_reg     <= req_store;
            addr_lo_reg   <= req_addr[1:0];
            wdata_reg     <= req_wdata;
            if (misalign) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
              state_reg      <= ST_RESP;
            end else if (req_store && op_norm == F3_W) begin
              ram_addr_reg  <= req_addr[ADDR_W+1:2];
              ram_wdata_reg <= req_wdata;
              ram_wen_reg   <= 1'b1;
              state_reg     <= ST_WR;
            end else begin
              ram_addr_reg <= req_addr[ADDR_W+1:2];
              state_reg    <= ST_RD;
            end
          end
        end
        ST_RD: state_reg <= ST_MERGE;
        // ram_rdata holds the word addressed during RD.
        ST_MERGE: begin
          if (store_reg) begin
            ram_wdata_reg <= store_word;
            ram_wen_reg   <= 1'b1;
            state_reg     <= ST_WR;
          end else begin
            resp_rdata_reg <= load_data;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_RESP;
          end
        end
        ST_WR: begin
          resp_rdata_reg <= 32'd0;
          resp_err_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = ram_wdata_reg;
  assign ram_wen    = ram_wen_reg;

  // Upper address bits wrap into the RAM and are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], RD_LAT_ONE};

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Directed self-checking bench for lsu_ram_bridge with a behavioural 1-cycle word RAM.
module tb_lsu_ram_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  lsu_ram_bridge #(.ADDR_W(16), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wen    (ram_wen),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one request; lat counts cycles from accept (T+1 == 1) to resp_valid.
  task automatic do_req(input logic [2:0] op, input logic st, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output logic wen1, output logic [15:0] addr1,
                        output logic any_wen);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_store = st;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat     = 1;
    wen1    = ram_wen;
    addr1   = ram_addr;
    any_wen = ram_wen;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      any_wen = any_wen | ram_wen;
    end
    rd  = resp_rdata;
    err = resp_err;
    $display("txn op=%0d store=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
             op, st, addr, wd, lat, rd, err);
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    logic        wen1;
    logic [15:0] addr1;
    logic        any_wen;

    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_store  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
    chk("rst_ram_addr",   {16'd0, ram_addr},   32'd0);
    chk("rst_ram_wdata",  ram_wdata,           32'd0);
    chk("rst_ram_wen",    {31'd0, ram_wen},    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x4 <- DEADBEEF
    do_req(3'd2, 1'b1, 32'h4, 32'hDEADBEEF, lat, rd, err, wen1, addr1, any_wen);
    chk("sw_wen_t1",   {31'd0, wen1},  32'd1);
    chk("sw_addr_t1",  {16'd0, addr1}, 32'd1);
    chk("sw_lat",      lat,            32'd2);
    chk("sw_rdata",    rd,             32'd0);
    chk("sw_mem1",     mem[1],         32'hDEADBEEF);

    do_req(3'd2, 1'b0, 32'h4, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lw_lat",      lat,              32'd3);
    chk("lw_rdata",    rd,               32'hDEADBEEF);
    chk("lw_no_wen",   {31'd0, any_wen}, 32'd0);

    // SB 0x6 <- 0x12 : lane 2 replaced
    do_req(3'd0, 1'b1, 32'h6, 32'h12, lat, rd, err, wen1, addr1, any_wen);
    chk("sb_lat",      lat,              32'd4);
    chk("sb_mem1",     mem[1],           32'hDE12BEEF);
    chk("sb_wen",      {31'd0, any_wen}, 32'd1);

    // SH 0x6 <- 0xABCD : upper half replaced
    do_req(3'd1, 1'b1, 32'h6, 32'h0000ABCD, lat, rd, err, wen1, addr1, any_wen);
    chk("sh_lat",      lat,    32'd4);
    chk("sh_mem1",     mem[1], 32'hABCDBEEF);

    do_req(3'd1, 1'b0, 32'h6, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lh_hi",       rd,     32'hFFFFABCD);
    do_req(3'd5, 1'b0, 32'h6, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lhu_hi",      rd,     32'h0000ABCD);
    do_req(3'd1, 1'b0, 32'h4, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lh_lo",       rd,     32'hFFFFBEEF);
    do_req(3'd0, 1'b0, 32'h5, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lb_lane1",    rd,     32'hFFFFFFBE);

    // LB/LBU at 0x7 on 0x80FFFFFF
    do_req(3'd2, 1'b1, 32'h4, 32'h80FFFFFF, lat, rd, err, wen1, addr1, any_wen);
    do_req(3'd0, 1'b0, 32'h7, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lb_7",        rd,     32'hFFFFFF80);
    do_req(3'd4, 1'b0, 32'h7, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("lbu_7",       rd,     32'h00000080);

    // Illegal funct3: load op 3 -> LW, store op 5 -> SW
    do_req(3'd3, 1'b0, 32'h4, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("ill_ld_rdata", rd,    32'h80FFFFFF);
    do_req(3'd5, 1'b1, 32'h8, 32'h11223344, lat, rd, err, wen1, addr1, any_wen);
    chk("ill_st_lat",  lat,    32'd2);
    chk("ill_st_mem2", mem[2], 32'h11223344);

    // Upper address bits wrap: 0x40008 maps to word 2
    do_req(3'd2, 1'b0, 32'h0004_0008, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("wrap_rdata",  rd,     32'h11223344);

    // Back-pressure: hold resp_ready low for 5 cycles in RESP
    resp_ready = 1'b0;
    do_req(3'd2, 1'b0, 32'h8, 32'h0, lat, rd, err, wen1, addr1, any_wen);
    chk("hold_lat",    lat,    32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid",  {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata",  resp_rdata,          32'h11223344);
      chk("hold_ready",  {31'd0, req_ready},  32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid",   {31'd0, resp_valid}, 32'd0);
    chk("rel_ready",   {31'd0, req_ready},  32'd1);

    // Reset during MERGE of SH 0x8: no write may reach the RAM
    begin
      logic wen_seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'd1;
      req_store = 1'b1;
      req_addr  = 32'h8;
      req_wdata = 32'h00005555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wen_seen  = ram_wen;
      @(posedge clk);
      #1;
      wen_seen  = wen_seen | ram_wen;
      rst = 1'b1;
      @(posedge clk);
      #1;
      wen_seen  = wen_seen | ram_wen;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        wen_seen = wen_seen | ram_wen;
      end
      $display("txn reset-in-merge SH addr=00000008 wen_seen=%0d mem2=%h", wen_seen, mem[2]);
      chk("rstmid_wen",   {31'd0, wen_seen},   32'd0);
      chk("rstmid_mem2",  mem[2],              32'h11223344);
      chk("rstmid_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstmid_ready", {31'd0, req_ready},  32'd1);
    end

    // Misaligned LW 0x5
    do_req(3'd2, 1'b0, 32'h5, 32'h0, lat, rd, err, wen1, addr1, any_wen);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lat",     lat,              32'd1);
    chk("mis_err",     {31'd0, err},     32'd1);
    chk("mis_rdata",   rd,               32'd0);
    chk("mis_no_wen",  {31'd0, any_wen}, 32'd0);
`else
    chk("mis_lat",     lat,              32'd3);
    chk("mis_err",     {31'd0, err},     32'd0);
    chk("mis_rdata",   rd,               32'h80FFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
